wptr_full_ctrl: RTL and testbench

WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/sync_r2w.sv | 30 +++
 rtl/wptr_full_ctrl.sv | 91 +++++++++
 tb/tb_wptr_full_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO defaults and Gray/binary pointer helpers
// Contents:
//   FIFO_ADDRSIZE, FIFO_DATASIZE : default address and data widths
//   PTR_W_MAX                    : widest pointer the helpers handle (ADDRSIZE 16 + 1)
//   bin2gray / gray2bin          : conversions used by the write and read pointer blocks
package fifo_pkg;

  localparam int FIFO_ADDRSIZE = 4;
  localparam int FIFO_DATASIZE = 8;
  localparam int PTR_W_MAX     = 17;

  // Callers zero-extend narrower pointers; leading zeros leave the result unchanged.
  function automatic logic [PTR_W_MAX-1:0] bin2gray(input logic [PTR_W_MAX-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [PTR_W_MAX-1:0] gray2bin(input logic [PTR_W_MAX-1:0] g);
    logic [PTR_W_MAX-1:0] b;
    b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
    for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_r2w.sv
// rtl/sync_r2w.sv - two-flop synchroniser for a Gray-coded pointer
// Ports:
//   wclk  in   destination clock
//   wrst  in   asynchronous active-high reset, clears both stages
//   d     in   WIDTH  pointer from the other clock domain
//   q     out  WIDTH  synchronised pointer (second stage)
// Also used as sync_w2r on the read side.
module sync_r2w #(
  parameter int WIDTH = 5
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] rq1;

  // Straight flop-to-flop path: no logic may sit between the stages.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      rq1 <= '0;
      q   <= '0;
    end else begin
      rq1 <= d;
      q   <= rq1;
    end
  end

endmodule

// File: rtl/wptr_full_ctrl.sv
// rtl/wptr_full_ctrl.sv - async FIFO write pointer, full/almost-full and overflow control
// Ports:
//   wclk          in   write-domain clock
//   wrst          in   asynchronous active-high reset
//   winc          in   write request
//   rptr          in   ADDRSIZE+1  Gray read pointer from the read domain
//   wovf_clr      in   clears the sticky overflow flag
//   waddr         out  ADDRSIZE    memory write address
//   wptr          out  ADDRSIZE+1  Gray write pointer to the read domain
//   wfull         out  FIFO full (registered), gates memory writes
//   walmost_full  out  occupancy >= AFULL_THRESH (registered)
//   wcount        out  ADDRSIZE+1  write-side occupancy estimate
//   woverflow     out  sticky: write attempted while full
module wptr_full_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE     = FIFO_ADDRSIZE,
  parameter int AFULL_THRESH = 2**ADDRSIZE - 2
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   rptr,
  input  logic                wovf_clr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wcount,
  output logic                woverflow
);

  localparam int                PW        = ADDRSIZE + 1;
  localparam logic [ADDRSIZE:0] AFULL_LVL = AFULL_THRESH[ADDRSIZE:0];

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wbinnext;
  logic [ADDRSIZE:0] wgraynext;
  logic [ADDRSIZE:0] rq2;
  logic [ADDRSIZE:0] rbin_s;
  logic [ADDRSIZE:0] full_pat;
  logic [ADDRSIZE:0] wdiff;
  logic              accept;

  sync_r2w #(.WIDTH(PW)) u_sync_r2w (
    .wclk (wclk),
    .wrst (wrst),
    .d    (rptr),
    .q    (rq2)
  );

  // A write while full is dropped; the pointer simply holds.
  assign accept    = winc & ~wfull;
  assign wbinnext  = wbin + {{ADDRSIZE{1'b0}}, accept};
  assign wgraynext = PW'(bin2gray(PTR_W_MAX'(wbinnext)));
  assign rbin_s    = PW'(gray2bin(PTR_W_MAX'(rq2)));

  // Full when the write pointer has lapped the read pointer by exactly one
  // depth: in Gray code that is the top two bits inverted, the rest equal.
  assign full_pat  = {~rq2[ADDRSIZE:ADDRSIZE-1], rq2[ADDRSIZE-2:0]};

  // Occupancy against a stale read pointer: never under-reports, so full and
  // almost-full release late rather than early.
  assign wdiff     = wbinnext - rbin_s;

  assign waddr     = wbin[ADDRSIZE-1:0];

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wcount       <= '0;
      woverflow    <= 1'b0;
    end else begin
      wbin         <= wbinnext;
      wptr         <= wgraynext;
      wfull        <= (wgraynext == full_pat);
      walmost_full <= (wdiff >= AFULL_LVL);
      wcount       <= wdiff;
      // Set has priority so an overflow coinciding with a clear is not lost.
      if (winc & wfull) begin
        woverflow <= 1'b1;
      end else if (wovf_clr) begin
        woverflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// tb/tb_wptr_full_ctrl.sv - self-checking bench for wptr_full_ctrl
module tb_wptr_full_ctrl;

  localparam int AS    = 4;
  localparam int DEPTH = 16;
  localparam int MOD   = 32;
  localparam int AFT   = 14;
  localparam int LOGN  = 1024;

  logic          wclk;
  logic          wrst;
  logic          winc;
  logic          wovf_clr;
  logic [AS:0]   rptr_bin;
  logic [AS:0]   rptr;
  logic [AS-1:0] waddr;
  logic [AS:0]   wptr;
  logic          wfull;
  logic          walmost_full;
  logic [AS:0]   wcount;
  logic          woverflow;

  int n_checks = 0;
  int n_pass   = 0;

  assign rptr = rptr_bin ^ (rptr_bin >> 1);

  wptr_full_ctrl #(.ADDRSIZE(AS), .AFULL_THRESH(AFT)) dut (
    .wclk         (wclk),
    .wrst         (wrst),
    .winc         (winc),
    .rptr         (rptr),
    .wovf_clr     (wovf_clr),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wcount       (wcount),
    .woverflow    (woverflow)
  );

  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask

  // Behavioural model: count of accepted writes, and the read pointer as the
  // write side can know it, i.e. the value the producer saw two edges ago.
  int m_wr, m_cnt, m_cyc;
  bit m_full, m_afull, m_ovf;
  int rlog [0:LOGN-1];

  function automatic int m_accept();
    return (winc && !m_full) ? 1 : 0;
  endfunction

  function automatic int m_seen_rd();
    return (m_cyc >= 2) ? rlog[(m_cyc - 2) % LOGN] : 0;
  endfunction

  function automatic int m_occ();
    return ((m_wr + m_accept()) - m_seen_rd() + 2 * MOD) % MOD;
  endfunction

  always @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      m_wr <= 0; m_cnt <= 0; m_cyc <= 0;
      m_full <= 1'b0; m_afull <= 1'b0; m_ovf <= 1'b0;
    end else begin
      m_wr    <= (m_wr + m_accept()) % MOD;
      m_cnt   <= m_occ();
      m_full  <= (m_occ() == DEPTH);
      m_afull <= (m_occ() >= AFT);
      m_ovf   <= (winc && m_full) ? 1'b1 : (wovf_clr ? 1'b0 : m_ovf);
      rlog[m_cyc % LOGN] <= int'(rptr_bin);
      m_cyc   <= m_cyc + 1;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  logic [AS:0]   prev_wptr;
  logic [AS-1:0] prev_waddr;
  bit in_wrap, wrap_seen, full_in_wrap;

  always @(negedge wclk) begin
    if (wrst) begin
      prev_wptr  <= '0;
      prev_waddr <= '0;
    end else begin
      chk("m_waddr", int'(waddr), m_wr % DEPTH);
      chk("m_wptr", int'(wptr), m_wr ^ (m_wr >> 1));
      chk("m_wfull", int'(wfull), int'(m_full));
      chk("m_walmost_full", int'(walmost_full), int'(m_afull));
      chk("m_wcount", int'(wcount), m_cnt);
      chk("m_woverflow", int'(woverflow), int'(m_ovf));
      if (wptr != prev_wptr) chk("wptr_one_bit", $countones(wptr ^ prev_wptr), 1);
      if (prev_wptr == 5'b10000 && wptr == 5'b00000 && prev_waddr == 4'd15 && waddr == 4'd0)
        wrap_seen <= 1'b1;
      if (in_wrap && wfull) full_in_wrap <= 1'b1;
      prev_wptr  <= wptr;
      prev_waddr <= waddr;
    end
  end

  task automatic step();
    @(posedge wclk);
    @(negedge wclk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_waddr"}, int'(waddr), 0);
    chk({tag, "_wptr"}, int'(wptr), 0);
    chk({tag, "_wfull"}, int'(wfull), 0);
    chk({tag, "_walmost_full"}, int'(walmost_full), 0);
    chk({tag, "_wcount"}, int'(wcount), 0);
    chk({tag, "_woverflow"}, int'(woverflow), 0);
  endtask

  initial begin
    wrst = 1'b1; winc = 1'b0; wovf_clr = 1'b0; rptr_bin = '0;
    in_wrap = 1'b0; wrap_seen = 1'b0; full_in_wrap = 1'b0;
    #3;
    chk_all_zero("reset");
    @(negedge wclk);
    #1 wrst = 1'b0;

    // Fill 16 slots with the reader parked at 0.
    for (int i = 0; i < DEPTH; i++) begin
      chk("fill_waddr", int'(waddr), i);
      winc = 1'b1;
      step();
      if (i == 12) chk("afull_after_13", int'(walmost_full), 0);
      if (i == 13) chk("afull_after_14", int'(walmost_full), 1);
      if (i == 14) chk("full_after_15", int'(wfull), 0);
    end
    chk("fill_wfull", int'(wfull), 1);
    chk("fill_wcount", int'(wcount), 16);
    chk("fill_wptr", int'(wptr), 5'b11000);

    // Writes while full are dropped and flagged.
    repeat (3) step();
    winc = 1'b0;
    chk("ovf_wptr", int'(wptr), 5'b11000);
    chk("ovf_waddr", int'(waddr), 0);
    chk("ovf_set", int'(woverflow), 1);
    step();
    chk("ovf_hold", int'(woverflow), 1);
    wovf_clr = 1'b1;
    step();
    wovf_clr = 1'b0;
    chk("ovf_clr", int'(woverflow), 0);

    // Set and clear together: set wins.
    winc = 1'b1; wovf_clr = 1'b1;
    step();
    winc = 1'b0; wovf_clr = 1'b0;
    chk("simul_ovf", int'(woverflow), 1);
    chk("simul_wptr", int'(wptr), 5'b11000);
    wovf_clr = 1'b1;
    step();
    wovf_clr = 1'b0;
    chk("simul_clr", int'(woverflow), 0);

    // Reader frees one slot: full releases on the third edge.
    rptr_bin = 5'd1;
    step();
    chk("rel_edge1_full", int'(wfull), 1);
    step();
    chk("rel_edge2_full", int'(wfull), 1);
    chk("rel_edge2_cnt", int'(wcount), 16);
    step();
    chk("rel_edge3_full", int'(wfull), 0);
    chk("rel_edge3_cnt", int'(wcount), 15);

    // Wrap: reader follows the writer closely, 40 writes from 16 -> 56 mod 32.
    rptr_bin = 5'd16;
    repeat (3) step();
    in_wrap = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rptr_bin = 5'(m_wr);
      winc = 1'b1;
      step();
    end
    winc = 1'b0;
    in_wrap = 1'b0;
    step();
    chk("wrap_seen", int'(wrap_seen), 1);
    chk("wrap_no_full", int'(full_in_wrap), 0);
    chk("wrap_waddr", int'(waddr), 8);
    chk("wrap_wptr", int'(wptr), 5'b10100);

    // Mid-operation reset clears everything without a clock edge.
    #2 wrst = 1'b1;
    #1;
    chk_all_zero("midrst");
    rptr_bin = '0;
    @(posedge wclk);
    @(negedge wclk);
    #1 wrst = 1'b0;
    winc = 1'b1;
    step();
    winc = 1'b0;
    chk("first_wr_waddr", int'(waddr), 1);
    chk("first_wr_wptr", int'(wptr), 5'b00001);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
